// File: rtl/rams_dist_pkg.sv
// Shared types and default geometry for the multi-port distributed RAM.
package rams_dist_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 6;
  localparam int NRD_DEF    = 2;

  // Clear sequencer states; reset lands in CLEAR so the array starts zeroed.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_e;

endpackage

// File: rtl/rams_dist_clr.sv
// Clear sequencer: walks every address once, writing zero, then idles.
module rams_dist_clr
  import rams_dist_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // State and address counter registers; reset restarts the clear from zero.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: CLEAR sweeps to the top address, IDLE waits for clr.
  always_comb begin
    // NOTE: defaults first, so no path leaves a signal unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        // clr is deliberately not looked at here: a running sweep never restarts.
        cnt_d = cnt_q + 1'b1;  // wraps to 0 on the last address
        if (cnt_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign clr_addr = cnt_q;
  assign clr_we   = busy;

endmodule

// File: rtl/rams_dist_mp.sv
// Distributed RAM: one byte-enabled read/write port plus NRD read-only ports,
// with a self-timed zeroing sequence after reset or on request.
module rams_dist_mp
  import rams_dist_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NRD     = NRD_DEF,
  parameter int OUT_REG = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [DATA_W/8-1:0]     be,
  input  logic [ADDR_W-1:0]       a,
  input  logic [DATA_W-1:0]       di,
  output logic [DATA_W-1:0]       spo,
  input  logic [NRD*ADDR_W-1:0]   dpra,
  output logic [NRD*DATA_W-1:0]   dpo,
  input  logic                    clr,
  output logic                    busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] ram [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_en;
  logic [DATA_W-1:0]     spo_rd;
  logic [NRD*DATA_W-1:0] dpo_rd;

  rams_dist_clr #(.ADDR_W(ADDR_W)) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  // User writes only in IDLE, and a clr request in the same cycle wins.
  assign wr_en = we && !busy && !clr;

  // Array update: clear sweep has priority, otherwise byte-masked user write.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset so it maps to distributed RAM; zeroing is
    // done by the clear sweep instead.
    if (clr_we) begin
      ram[clr_addr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) ram[a][8*i +: 8] <= di[8*i +: 8];
      end
    end
  end

  // Asynchronous read of every port, blanked while the sweep runs.
  always_comb begin
    spo_rd = busy ? '0 : ram[a];
    dpo_rd = '0;
    for (int k = 0; k < NRD; k++) begin
      dpo_rd[k*DATA_W +: DATA_W] = busy ? '0 : ram[dpra[k*ADDR_W +: ADDR_W]];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      // Registered outputs: read-first, since they capture pre-edge contents.
      always_ff @(posedge clk) begin
        if (rst) begin
          spo <= '0;
          dpo <= '0;
        end else begin
          spo <= spo_rd;
          dpo <= dpo_rd;
        end
      end
    end else begin : g_out_comb
      assign spo = spo_rd;
      assign dpo = dpo_rd;
    end
  endgenerate

endmodule

// File: tb/tb_rams_dist_mp.sv
// Directed bench: one asynchronous-output and one registered-output instance
// share the same stimulus, so both hold identical array contents.
module tb_rams_dist_mp;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we  = 1'b0;
  logic [1:0]    be  = 2'b00;
  logic [AW-1:0] a   = '0;
  logic [DW-1:0] di  = '0;
  logic [NR*AW-1:0] dpra = '0;
  logic          clr = 1'b0;

  logic [DW-1:0]    spo_c, spo_r;
  logic [NR*DW-1:0] dpo_c, dpo_r;
  logic             busy_c, busy_r;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rams_dist_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .OUT_REG(0)) dut_c (
    .clk(clk), .rst(rst), .we(we), .be(be), .a(a), .di(di), .spo(spo_c),
    .dpra(dpra), .dpo(dpo_c), .clr(clr), .busy(busy_c)
  );

  rams_dist_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .OUT_REG(1)) dut_r (
    .clk(clk), .rst(rst), .we(we), .be(be), .a(a), .di(di), .spo(spo_r),
    .dpra(dpra), .dpo(dpo_r), .clr(clr), .busy(busy_r)
  );

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until busy drops, bounded at 200.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy_c && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (busy_c !== 1'b1 || busy_r !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy: got %b/%b want 1/1", busy_c, busy_r);
    end
    checks++;
    if (spo_r !== 16'h0000 || dpo_r !== 32'h0) begin
      failures++;
      $display("FAIL reset_regout: spo=%h dpo=%h want 0/0", spo_r, dpo_r);
    end
    rst = 1'b0;
    wait_idle(n);
    checks++;
    if (n !== 64) begin
      failures++;
      $display("FAIL reset_clear_len: got %0d edges want 64", n);
    end
    checks++;
    if (busy_r !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy_r_low: got %b want 0", busy_r);
    end
    for (int i = 0; i < 64; i++) begin
      a    = AW'(i);
      dpra = {AW'(i), AW'(63 - i)};
      #1;
      checks++;
      if (spo_c !== 16'h0 || dpo_c !== 32'h0) begin
        failures++;
        $display("FAIL reset_zero[%0d]: spo=%h dpo=%h want 0", i, spo_c, dpo_c);
      end
    end
  endtask

  task automatic test_byte_enable();
    we = 1'b1; be = 2'b11; a = 6'd5; di = 16'hBEEF;
    tick();
    be = 2'b01; di = 16'h1234;
    tick();
    a = 6'd6; be = 2'b11; di = 16'hBEEF;
    tick();
    be = 2'b10; di = 16'h1234;
    tick();
    we = 1'b0; be = 2'b00;
    a = 6'd5; dpra = {6'd6, 6'd5};
    #1;
    checks++;
    if (spo_c !== 16'hBE34) begin
      failures++;
      $display("FAIL be_low_spo: got %h want be34", spo_c);
    end
    checks++;
    if (dpo_c !== {16'h12EF, 16'hBE34}) begin
      failures++;
      $display("FAIL be_dpo: got %h want 12efbe34", dpo_c);
    end
    tick();
    checks++;
    if (spo_r !== 16'hBE34 || dpo_r !== {16'h12EF, 16'hBE34}) begin
      failures++;
      $display("FAIL be_regout: spo=%h dpo=%h want be34/12efbe34", spo_r, dpo_r);
    end
    // Identical addresses on both read ports return identical data.
    dpra = {6'd5, 6'd5};
    #1;
    checks++;
    if (dpo_c !== {16'hBE34, 16'hBE34}) begin
      failures++;
      $display("FAIL same_addr: got %h want be34be34", dpo_c);
    end
  endtask

  task automatic test_read_first();
    we = 1'b1; be = 2'b11; a = 6'd7; di = 16'hAAAA;
    tick();
    di = 16'h5555; dpra = {6'd5, 6'd7};
    tick();
    we = 1'b0; be = 2'b00;
    checks++;
    if (dpo_r[15:0] !== 16'hAAAA) begin
      failures++;
      $display("FAIL read_first_old: got %h want aaaa", dpo_r[15:0]);
    end
    checks++;
    if (dpo_c[15:0] !== 16'h5555 || spo_c !== 16'h5555) begin
      failures++;
      $display("FAIL write_visible: dpo0=%h spo=%h want 5555", dpo_c[15:0], spo_c);
    end
    tick();
    checks++;
    if (dpo_r !== {16'hBE34, 16'h5555}) begin
      failures++;
      $display("FAIL read_first_new: got %h want be345555", dpo_r);
    end
  endtask

  task automatic test_clr_wins();
    int n;
    clr = 1'b1; we = 1'b1; be = 2'b11; a = 6'd3; di = 16'hFFFF;
    tick();
    clr = 1'b0; we = 1'b0; be = 2'b00;
    checks++;
    if (busy_c !== 1'b1 || spo_c !== 16'h0) begin
      failures++;
      $display("FAIL clr_enter: busy=%b spo=%h want 1/0", busy_c, spo_c);
    end
    wait_idle(n);
    checks++;
    if (n !== 64) begin
      failures++;
      $display("FAIL clr_len: got %0d edges want 64", n);
    end
    dpra = {6'd5, 6'd7};
    #1;
    checks++;
    if (spo_c !== 16'h0 || dpo_c !== 32'h0) begin
      failures++;
      $display("FAIL clr_zero: spo=%h dpo=%h want 0/0", spo_c, dpo_c);
    end
  endtask

  task automatic test_clr_ignored();
    int n;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wait_idle(n);
    checks++;
    if (n !== 43) begin
      failures++;
      $display("FAIL clr_ignored_len: got %0d edges want 43", n);
    end
  endtask

  task automatic test_rst_mid_clear();
    int n;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy_c !== 1'b1 || spo_r !== 16'h0) begin
      failures++;
      $display("FAIL rst_mid_state: busy=%b spo_r=%h want 1/0", busy_c, spo_r);
    end
    wait_idle(n);
    checks++;
    if (n !== 64) begin
      failures++;
      $display("FAIL rst_mid_len: got %0d edges want 64", n);
    end
  endtask

  task automatic test_we_during_busy();
    int n;
    int bad;
    we = 1'b1; be = 2'b11; a = 6'd9; di = 16'h1357;
    tick();
    dpra = {6'd9, 6'd9};
    clr = 1'b1; we = 1'b0;
    tick();
    clr = 1'b0;
    we = 1'b1; di = 16'hABCD;
    n   = 0;
    bad = 0;
    if (spo_c !== 16'h0 || dpo_c !== 32'h0) bad++;
    while (busy_c && n < 200) begin
      if (n == 63) we = 1'b0;
      tick();
      n++;
      if (busy_c && (spo_c !== 16'h0 || dpo_c !== 32'h0)) bad++;
      if (spo_r !== 16'h0 || dpo_r !== 32'h0) bad++;
    end
    we = 1'b0; be = 2'b00;
    checks++;
    if (n !== 64) begin
      failures++;
      $display("FAIL busy_we_len: got %0d edges want 64", n);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL busy_outputs: %0d nonzero samples want 0", bad);
    end
    #1;
    checks++;
    if (spo_c !== 16'h0 || dpo_c !== 32'h0) begin
      failures++;
      $display("FAIL busy_we_ignored: spo=%h dpo=%h want 0/0", spo_c, dpo_c);
    end
  endtask

  initial begin
    test_reset();
    test_byte_enable();
    test_read_first();
    test_clr_wins();
    test_clr_ignored();
    test_rst_mid_clear();
    test_we_during_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
